// File: rtl/pma_bus_arbiter.sv
// Round-robin arbiter between the fetch and data ports onto one memory bus, with a
// physical-memory-attribute check per request and a response timeout.
module pma_bus_arbiter #(
  parameter int XLEN        = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              ireq_valid_i,
  output logic              ireq_ready_o,
  input  logic [XLEN-1:0]   ireq_addr_i,
  input  logic              dreq_valid_i,
  output logic              dreq_ready_o,
  input  logic [XLEN-1:0]   dreq_addr_i,
  input  logic              dreq_we_i,
  input  logic [XLEN-1:0]   dreq_wdata_i,
  input  logic [XLEN/8-1:0] dreq_wstrb_i,
  output logic              irsp_valid_o,
  output logic              drsp_valid_o,
  output logic [XLEN-1:0]   rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              slv_valid_o,
  input  logic              slv_ready_i,
  output logic [XLEN-1:0]   slv_addr_o,
  output logic              slv_we_o,
  output logic [XLEN-1:0]   slv_wdata_o,
  output logic [XLEN/8-1:0] slv_wstrb_o,
  output logic [2:0]        slv_sel_o,
  input  logic              slv_rvalid_i,
  input  logic [XLEN-1:0]   slv_rdata_i
);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam int SW    = XLEN / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t           state_q;
  logic             prio_d_q;  // 1: the data port wins the next tie
  logic             port_q;    // 1: the data port owns the current transaction
  logic [CNT_W-1:0] cnt_q;
  logic             slv_valid_q, slv_we_q, irsp_q, drsp_q, err_q;
  logic [XLEN-1:0]  slv_addr_q, slv_wdata_q, rdata_q;
  logic [SW-1:0]    slv_wstrb_q;
  logic [2:0]       sel_q;

  // First matching region wins: MEM, then UART, then TIMER.
  function automatic logic [2:0] region_sel(input logic [XLEN-1:0] a);
    region_sel = 3'b000;
    if ((a & ~XLEN'(32'h000F_FFFF)) == XLEN'(32'h4000_0000))      region_sel = 3'b001;
    else if ((a & ~XLEN'(32'h0000_000F)) == XLEN'(32'h2000_0000)) region_sel = 3'b010;
    else if ((a & ~XLEN'(32'h0000_0007)) == XLEN'(32'h3000_0000)) region_sel = 3'b100;
  endfunction

  // MEM is RWX, UART is RW, TIMER is R-only.
  function automatic logic pma_fault(input logic is_data, input logic we, input logic [2:0] sel);
    if (!is_data)  pma_fault = !sel[0];
    else if (we)   pma_fault = !(sel[0] | sel[1]);
    else           pma_fault = (sel == 3'b000);
  endfunction

  logic            gnt_i, gnt_d;
  logic [XLEN-1:0] acc_addr, acc_wdata;
  logic            acc_we, acc_fault;
  logic [SW-1:0]   acc_wstrb;
  logic [2:0]      acc_sel;

  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (state_q == IDLE) begin
      if (ireq_valid_i && dreq_valid_i) begin
        gnt_d = prio_d_q;
        gnt_i = ~prio_d_q;
      end else begin
        gnt_i = ireq_valid_i;
        gnt_d = dreq_valid_i;
      end
    end
    acc_addr  = gnt_d ? dreq_addr_i : ireq_addr_i;
    acc_we    = gnt_d & dreq_we_i;
    acc_wdata = gnt_d ? dreq_wdata_i : '0;
    acc_wstrb = gnt_d ? dreq_wstrb_i : '0;
    acc_sel   = region_sel(acc_addr);
    acc_fault = pma_fault(gnt_d, acc_we, acc_sel);
  end

  assign ireq_ready_o = gnt_i;
  assign dreq_ready_o = gnt_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      prio_d_q    <= 1'b0;
      port_q      <= 1'b0;
      cnt_q       <= '0;
      slv_valid_q <= 1'b0;
      slv_we_q    <= 1'b0;
      slv_addr_q  <= '0;
      slv_wdata_q <= '0;
      slv_wstrb_q <= '0;
      sel_q       <= '0;
      irsp_q      <= 1'b0;
      drsp_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
    end else begin
      irsp_q <= 1'b0;
      drsp_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (gnt_i || gnt_d) begin
            prio_d_q    <= gnt_i;
            port_q      <= gnt_d;
            slv_addr_q  <= acc_addr;
            slv_we_q    <= acc_we;
            slv_wdata_q <= acc_wdata;
            slv_wstrb_q <= acc_wstrb;
            if (acc_fault) begin
              err_q   <= 1'b1;
              rdata_q <= '0;
              irsp_q  <= gnt_i;
              drsp_q  <= gnt_d;
              state_q <= RESP;
            end else begin
              slv_valid_q <= 1'b1;
              sel_q       <= acc_sel;
              state_q     <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (slv_ready_i) begin
            slv_valid_q <= 1'b0;
            sel_q       <= '0;
            cnt_q       <= '0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (slv_rvalid_i) begin
            rdata_q <= slv_rdata_i;
            err_q   <= 1'b0;
            irsp_q  <= ~port_q;
            drsp_q  <= port_q;
            state_q <= RESP;
          end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            irsp_q  <= ~port_q;
            drsp_q  <= port_q;
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign irsp_valid_o = irsp_q;
  assign drsp_valid_o = drsp_q;
  assign rsp_rdata_o  = rdata_q;
  assign rsp_err_o    = err_q;
  assign slv_valid_o  = slv_valid_q;
  assign slv_addr_o   = slv_addr_q;
  assign slv_we_o     = slv_we_q;
  assign slv_wdata_o  = slv_wdata_q;
  assign slv_wstrb_o  = slv_wstrb_q;
  assign slv_sel_o    = sel_q;

endmodule
